wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter for the CPU register file's single write port. It accepts results from two producers, the ALU result path and the memory load-return path, over valid/ready handshakes and buffers one entry per producer. It arbitrates round-robin between them and drives a registered write strobe, address and data straight into the register file's write port. Writes to unimplemented register addresses are discarded here, so the register file only ever sees writes to r1..r10.

## Interface
- `NUM_REGS`, 10: highest writable register index. Writes to addresses 1..NUM_REGS are legal.
- `DATA_W`, 32: result data width.
- `iClk` in 1: clock. All state changes on the rising edge.
- `nRst` in 1: reset. Asynchronous, active-low.
- `iAluValid` in 1: ALU result offered.
- `iAluAddr` in 5: ALU destination register.
- `iAluData` in DATA_W: ALU result.
- `oAluReady` out 1: ALU slot can accept this cycle.
- `iMemValid` in 1: load return offered.
- `iMemAddr` in 5: load destination register.
- `iMemData` in DATA_W: load data.
- `oMemReady` out 1: memory slot can accept this cycle.
- `oWrite` out 1: write strobe to the register file.
- `oAddrC` out 5: write address to the register file.
- `oRegC` out DATA_W: write data to the register file.
- `oBusy` out 1: at least one slot holds an entry, or `oWrite` is high.

## Operation
- Each producer has a one-entry slot (held flag, addr, data). A transfer occurs on an edge where valid && ready.
- Ready is combinational: `ready = !held || granted`. An entry leaving the slot frees it for a same-cycle refill.
- Producers must hold valid, addr and data stable until accepted.
- Grant is combinational from the held flags:
  - Only one slot held: that slot wins.
  - Both held: round-robin. Pointer `rr` names the preferred slot; after a both-held grant, `rr` flips to the loser.
  - A single-held grant leaves `rr` unchanged.
- On an edge with a grant, the output register loads the winner's addr and data.
  - `oWrite` is set to 1 when 1 ≤ addr ≤ NUM_REGS, else 0 (dropped write). The dropped entry still leaves its slot.
- With no grant, `oWrite` is cleared and `oAddrC`/`oRegC` hold their values.
- Same destination from both producers: both writes issue in grant order. The later one persists in the register file.
- Reset values:
  - Both slots empty.
  - `rr` = Mem.
  - `oWrite`, `oAddrC`, `oRegC` all 0.
  - `oBusy` 0.
  - Drop counter 0.
- Reset mid-operation: all held entries are lost and no write is issued. `oWrite` falls immediately on the asynchronous assertion.

## Timing
- Latency: transfer on edge E0 → slot held in cycle E0+ → output register loaded at E1 → `oWrite` high in the cycle after E1 → register file writes at E2.
- Single producer streaming with valid held high: ready stays 1 and one write per cycle reaches the register file.
- Both producers streaming: strict alternation, Mem first after reset. Each sees ready = 1 on alternate cycles.
- A slot waits at most one cycle for grant.

## Configuration
- `WB_DROPCNT_EN` defined:
  - Adds output `oDropCnt` out 8: saturating count (stops at 255) of grants with an illegal address.
  - Cleared only by reset.
- Not defined: the port and the counter are absent. Dropped writes are discarded silently.

## Structure
- Shared CPU package holds:
  - `NUM_REGS` (10), `REG_ADDR_W` (5), `DATA_W` (32).
  - Source-select enum `WB_SRC_ALU` / `WB_SRC_MEM`.
- One sub-module, `wb_slot`: the one-entry holding register with its valid/ready logic, instantiated once for ALU and once for Mem. Arbitration and the output register live in `wb_arbiter`.

## Test plan
- Reset → `oWrite`=0, `oAddrC`=0, `oRegC`=0, both readies 1, `oBusy`=0. Assert `nRst` low mid-stream with both slots held → `oWrite` drops at once; after release, no stale write issues.
- Single ALU transfer addr 3, data 0xDEADBEEF at edge E0 → `oWrite`=1, `oAddrC`=3, `oRegC`=0xDEADBEEF in the cycle after E1, for exactly one cycle.
- Both producers transfer on the same edge: Mem addr 5 data 0x11, ALU addr 5 data 0x22 → Mem write on the first `oWrite` cycle, ALU on the next. Register 5 ends at 0x22. The next contended pair grants ALU first.
- ALU streams 8 writes with valid held high, addr 1..8, data equal to addr → 8 consecutive `oWrite` cycles in order, `oAluReady` never 0.
- Mem addr 0 then addr 15, data 0xFF → `oWrite` stays 0 for both. With `WB_DROPCNT_EN`, `oDropCnt` goes 0→1→2. 300 further drops → saturates at 255.
- Both producers streaming 6 writes each → alternating Mem/ALU writes, each ready toggling 1/0, 12 total writes, no loss or duplication.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU write-back definitions: register file geometry, result entry layout
// and the source-select encoding used by the write-back arbiter.
package wb_arbiter_pkg;

    localparam int NUM_REGS   = 10;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] MAX_REG_ADDR = REG_ADDR_W'(NUM_REGS);

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // r0 is hardwired and anything above NUM_REGS does not exist in the register file.
    function automatic logic wb_addr_legal(input logic [REG_ADDR_W-1:0] addr);
        return (addr != '0) && (addr <= MAX_REG_ADDR);
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single write-back producer.
// Valid/ready: a transfer happens on a rising edge where valid && ready; ready = !held || grant.
module wb_slot
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     data,
    input  logic                  grant,
    output logic                  ready,
    output logic                  held,
    output wb_entry_t             entry
);

    // A granted entry leaves at this edge, so the slot can refill in the same cycle.
    assign ready = !held || grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held  <= 1'b0;
            entry <= '0;
        end else if (valid && ready) begin
            held       <= 1'b1;
            entry.addr <= addr;
            entry.data <= data;
        end else if (grant) begin
            held <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter between the ALU and load-return paths, feeding the
// register file write port. Optional drop counter is enabled by defining WB_DROPCNT_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                  iClk,
    input  logic                  nRst,
    input  logic                  iAluValid,
    input  logic [REG_ADDR_W-1:0] iAluAddr,
    input  logic [DATA_W-1:0]     iAluData,
    output logic                  oAluReady,
    input  logic                  iMemValid,
    input  logic [REG_ADDR_W-1:0] iMemAddr,
    input  logic [DATA_W-1:0]     iMemData,
    output logic                  oMemReady,
    output logic                  oWrite,
    output logic [REG_ADDR_W-1:0] oAddrC,
    output logic [DATA_W-1:0]     oRegC,
    output logic                  oBusy
`ifdef WB_DROPCNT_EN
    ,
    output logic [7:0]            oDropCnt
`endif
);

    logic      alu_held;
    logic      mem_held;
    logic      alu_grant;
    logic      mem_grant;
    logic      any_grant;
    wb_entry_t alu_entry;
    wb_entry_t mem_entry;
    wb_entry_t win_entry;
    wb_src_e   rr;

    wb_slot u_alu_slot (
        .clk   (iClk),
        .rst_n (nRst),
        .valid (iAluValid),
        .addr  (iAluAddr),
        .data  (iAluData),
        .grant (alu_grant),
        .ready (oAluReady),
        .held  (alu_held),
        .entry (alu_entry)
    );

    wb_slot u_mem_slot (
        .clk   (iClk),
        .rst_n (nRst),
        .valid (iMemValid),
        .addr  (iMemAddr),
        .data  (iMemData),
        .grant (mem_grant),
        .ready (oMemReady),
        .held  (mem_held),
        .entry (mem_entry)
    );

    // A lone held slot always wins; rr only breaks ties.
    assign alu_grant = alu_held && (!mem_held || rr == WB_SRC_ALU);
    assign mem_grant = mem_held && (!alu_held || rr == WB_SRC_MEM);
    assign any_grant = alu_grant || mem_grant;
    assign win_entry = mem_grant ? mem_entry : alu_entry;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            rr <= WB_SRC_MEM;
        end else if (alu_held && mem_held) begin
            rr <= mem_grant ? WB_SRC_ALU : WB_SRC_MEM;
        end
    end

    // Illegal destinations still consume their grant but never raise the strobe.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oWrite <= 1'b0;
            oAddrC <= '0;
            oRegC  <= '0;
        end else if (any_grant) begin
            oWrite <= wb_addr_legal(win_entry.addr);
            oAddrC <= win_entry.addr;
            oRegC  <= win_entry.data;
        end else begin
            oWrite <= 1'b0;
        end
    end

    assign oBusy = alu_held || mem_held || oWrite;

`ifdef WB_DROPCNT_EN
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oDropCnt <= '0;
        end else if (any_grant && !wb_addr_legal(win_entry.addr) && oDropCnt != 8'hFF) begin
            oDropCnt <= oDropCnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: cycle vector table plus streaming, reset and
// drop-counter sequences checked against a write scoreboard.
module tb_wb_arbiter;

    logic        iClk;
    logic        nRst;
    logic        iAluValid;
    logic [4:0]  iAluAddr;
    logic [31:0] iAluData;
    logic        oAluReady;
    logic        iMemValid;
    logic [4:0]  iMemAddr;
    logic [31:0] iMemData;
    logic        oMemReady;
    logic        oWrite;
    logic [4:0]  oAddrC;
    logic [31:0] oRegC;
    logic        oBusy;
`ifdef WB_DROPCNT_EN
    logic [7:0]  oDropCnt;
`endif

    wb_arbiter dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iAluValid (iAluValid),
        .iAluAddr  (iAluAddr),
        .iAluData  (iAluData),
        .oAluReady (oAluReady),
        .iMemValid (iMemValid),
        .iMemAddr  (iMemAddr),
        .iMemData  (iMemData),
        .oMemReady (oMemReady),
        .oWrite    (oWrite),
        .oAddrC    (oAddrC),
        .oRegC     (oRegC),
        .oBusy     (oBusy)
`ifdef WB_DROPCNT_EN
        ,
        .oDropCnt  (oDropCnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iAluValid = 1'b0; iAluAddr = '0; iAluData = '0;
        iMemValid = 1'b0; iMemAddr = '0; iMemData = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRst = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        nRst = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [36:0] exp_q[$];
    int          wr_cyc_q[$];
    logic [31:0] rf[32];
    bit          sb_en = 1'b0;
    int          cyc = 0;
    int          wr_cnt = 0;

    always @(negedge iClk) begin
        cyc++;
        if (oWrite) begin
            rf[oAddrC] = oRegC;
            wr_cnt++;
            check("write_addr_legal", 64'(oAddrC >= 5'd1 && oAddrC <= 5'd10), 64'(1));
            if (sb_en) begin
                wr_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 64'({oAddrC, oRegC}), 64'(0));
                end else begin
                    check("sb_write", 64'({oAddrC, oRegC}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_alu(input logic [4:0] a, input logic [31:0] d, output int n_stall);
        logic r;
        bit   acc;
        n_stall = 0;
        acc = 1'b0;
        iAluValid = 1'b1; iAluAddr = a; iAluData = d;
        for (int t = 0; t < 16 && !acc; t++) begin
            @(negedge iClk);
            r = oAluReady;
            @(posedge iClk);
            #1;
            if (r) acc = 1'b1;
            else n_stall++;
        end
        if (!acc) check("alu_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drive_mem(input logic [4:0] a, input logic [31:0] d, output int n_stall);
        logic r;
        bit   acc;
        n_stall = 0;
        acc = 1'b0;
        iMemValid = 1'b1; iMemAddr = a; iMemData = d;
        for (int t = 0; t < 16 && !acc; t++) begin
            @(negedge iClk);
            r = oMemReady;
            @(posedge iClk);
            #1;
            if (r) acc = 1'b1;
            else n_stall++;
        end
        if (!acc) check("mem_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge iClk);
        repeat (2) @(posedge iClk);
        #1;
        check(name, 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        mem_v;
        logic [4:0]  mem_a;
        logic [31:0] mem_d;
        logic        e_alu_rdy;
        logic        e_mem_rdy;
        logic        e_w;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_busy;
        logic [7:0]  e_drop;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    initial begin
        int s;
        int st_a;
        int st_m;
        int span;
        int wr_before;

        // inputs applied for a cycle; expectations sampled on that cycle's falling edge
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 8'd0};
        vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 8'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 8'd0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 8'd0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 5'd5,  32'h22,       1'b1, 5'd5,  32'h11, 1'b1, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b1, 5'd5,  32'h11,       1'b1, 8'd0};
        vecs[8]  = '{1'b1, 5'd7,  32'h44,       1'b1, 5'd6,  32'h33, 1'b1, 1'b1, 1'b1, 5'd5,  32'h22,       1'b1, 8'd0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 5'd5,  32'h22,       1'b1, 8'd0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b1, 5'd7,  32'h44,       1'b1, 8'd0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFF, 1'b1, 1'b1, 1'b1, 5'd6,  32'h33,       1'b1, 8'd0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 32'hFF, 1'b1, 1'b1, 1'b0, 5'd6,  32'h33,       1'b1, 8'd0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'hFF,       1'b1, 8'd1};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 1'b0, 5'd15, 32'hFF,       1'b0, 8'd2};

        for (int i = 0; i < 32; i++) rf[i] = '0;
        idle_inputs();
        nRst = 1'b0;
        #1;
        check("async_reset_write", 64'(oWrite), 64'(0));
        do_reset();

        // ---- table: reset state, single write, contention, drops ----
        for (int i = 0; i < NV; i++) begin
            iAluValid = vecs[i].alu_v; iAluAddr = vecs[i].alu_a; iAluData = vecs[i].alu_d;
            iMemValid = vecs[i].mem_v; iMemAddr = vecs[i].mem_a; iMemData = vecs[i].mem_d;
            @(negedge iClk);
            check($sformatf("v%0d_alu_ready", i), 64'(oAluReady), 64'(vecs[i].e_alu_rdy));
            check($sformatf("v%0d_mem_ready", i), 64'(oMemReady), 64'(vecs[i].e_mem_rdy));
            check($sformatf("v%0d_write", i),     64'(oWrite),    64'(vecs[i].e_w));
            check($sformatf("v%0d_addr", i),      64'(oAddrC),    64'(vecs[i].e_a));
            check($sformatf("v%0d_data", i),      64'(oRegC),     64'(vecs[i].e_d));
            check($sformatf("v%0d_busy", i),      64'(oBusy),     64'(vecs[i].e_busy));
`ifdef WB_DROPCNT_EN
            check($sformatf("v%0d_dropcnt", i),   64'(oDropCnt),  64'(vecs[i].e_drop));
`endif
            @(posedge iClk);
            #1;
        end
        check("rf5_last_writer", 64'(rf[5]), 64'(32'h22));
        check("rf6_value", 64'(rf[6]), 64'(32'h33));

        // ---- ALU streaming 8 writes, ready never drops ----
        sb_en = 1'b1;
        wr_cyc_q.delete();
        st_a = 0;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back({5'(k), 32'(k)});
            drive_alu(5'(k), 32'(k), s);
            st_a += s;
        end
        iAluValid = 1'b0;
        wait_drain("alu_stream_drain");
        check("alu_stream_stalls", 64'(st_a), 64'(0));
        check("alu_stream_count", 64'(wr_cyc_q.size()), 64'(8));
        span = (wr_cyc_q.size() == 8) ? wr_cyc_q[7] - wr_cyc_q[0] : -1;
        check("alu_stream_span", 64'(span), 64'(7));

        // ---- both streaming from reset: Mem first, strict alternation ----
        do_reset();
        wr_cyc_q.delete();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back({5'(k + 1), 32'hA000_0000 + 32'(k)});
            exp_q.push_back({5'(k + 2), 32'hB000_0000 + 32'(k)});
        end
        st_a = 0;
        st_m = 0;
        fork
            begin
                int sm;
                for (int k = 0; k < 6; k++) begin
                    drive_mem(5'(k + 1), 32'hA000_0000 + 32'(k), sm);
                    st_m += sm;
                end
                iMemValid = 1'b0;
            end
            begin
                int sa;
                for (int k = 0; k < 6; k++) begin
                    drive_alu(5'(k + 2), 32'hB000_0000 + 32'(k), sa);
                    st_a += sa;
                end
                iAluValid = 1'b0;
            end
        join
        wait_drain("dual_stream_drain");
        check("dual_mem_stalls", 64'(st_m), 64'(4));
        check("dual_alu_stalls", 64'(st_a), 64'(5));
        check("dual_stream_count", 64'(wr_cyc_q.size()), 64'(12));
        span = (wr_cyc_q.size() == 12) ? wr_cyc_q[11] - wr_cyc_q[0] : -1;
        check("dual_stream_span", 64'(span), 64'(11));

        // ---- reset mid-operation: rr now points at ALU, Mem still held ----
        iAluValid = 1'b1; iAluAddr = 5'd9;  iAluData = 32'h99;
        iMemValid = 1'b1; iMemAddr = 5'd10; iMemData = 32'hAA;
        @(posedge iClk);
        #1;
        idle_inputs();
        @(posedge iClk);
        #1;
        check("pre_reset_write", 64'(oWrite), 64'(1));
        check("pre_reset_addr", 64'(oAddrC), 64'(9));
        check("pre_reset_mem_held", 64'(oBusy), 64'(1));
        #2;
        nRst = 1'b0;
        #1;
        check("async_drop_write", 64'(oWrite), 64'(0));
        check("async_drop_addr", 64'(oAddrC), 64'(0));
        check("async_drop_data", 64'(oRegC), 64'(0));
        check("async_drop_busy", 64'(oBusy), 64'(0));
        check("async_drop_readies", 64'({oAluReady, oMemReady}), 64'(2'b11));
        wr_before = wr_cnt;
        @(posedge iClk);
        @(negedge iClk);
        nRst = 1'b1;
        repeat (6) @(posedge iClk);
        #1;
        check("no_stale_write", 64'(wr_cnt), 64'(wr_before));

`ifdef WB_DROPCNT_EN
        // ---- drop counter saturation ----
        check("dropcnt_after_reset", 64'(oDropCnt), 64'(0));
        for (int k = 0; k < 302; k++) begin
            drive_mem(5'd31, 32'(k), s);
        end
        iMemValid = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("dropcnt_saturated", 64'(oDropCnt), 64'(255));
`endif

        sb_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
